// File: rtl/centroid_update.sv
// Accumulates per-cluster coordinate sums/counts, then divides serially to refresh 3 centroids.
// Latency: epoch_end -> 192 DIVIDE cycles (6 x 32-cycle divisions) -> 1 UPDATE cycle with update_valid.
// Backpressure: in_ready only in ACCUM; in_valid and epoch_end outside ACCUM are ignored.
module centroid_update #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_x,
    input  logic [DATA_W-1:0] data_y,
    input  logic [1:0]        cluster_id,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              epoch_end,
    output logic [DATA_W-1:0] c1_x,
    output logic [DATA_W-1:0] c1_y,
    output logic [DATA_W-1:0] c2_x,
    output logic [DATA_W-1:0] c2_y,
    output logic [DATA_W-1:0] c3_x,
    output logic [DATA_W-1:0] c3_y,
    output logic              update_valid,
    output logic              busy,
    output logic              cnt_overflow
);
    // Sums are wide enough that cnt_max * data_max never wraps.
    localparam int SUM_W = DATA_W + CNT_W;
    // Every division runs a fixed 32 steps over the zero-extended dividend (SUM_W <= 32).
    localparam int DIV_CYC = 32;
    localparam logic [4:0] LAST_BIT = 5'd31;

    localparam logic [DATA_W-1:0] C1_X_RST = DATA_W'(16'h0200);
    localparam logic [DATA_W-1:0] C1_Y_RST = DATA_W'(16'h0200);
    localparam logic [DATA_W-1:0] C2_X_RST = DATA_W'(16'h0600);
    localparam logic [DATA_W-1:0] C2_Y_RST = DATA_W'(16'h0600);
    localparam logic [DATA_W-1:0] C3_X_RST = DATA_W'(16'h0180);
    localparam logic [DATA_W-1:0] C3_Y_RST = DATA_W'(16'h0800);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0][SUM_W-1:0]  sum_x, sum_y;
    logic [2:0][CNT_W-1:0]  cnt;
    logic [2:0][DATA_W-1:0] cent_x, cent_y;
    logic [4:0][DATA_W-1:0] shadow;
    logic [5:0][DATA_W-1:0] result;

    logic [CNT_W-1:0]   rem, rem_next;
    logic [CNT_W:0]     rem_shift;
    logic [DATA_W-1:0]  quo, quo_next;
    logic               q_bit;
    logic [4:0]         bit_cnt;
    logic [2:0]         div_idx;
    logic [SUM_W-1:0]   dividend;
    logic [DIV_CYC-1:0] dividend_ext;
    logic [CNT_W-1:0]   divisor;
    logic               div_done;
    logic               last_step;

    assign in_ready     = (state_q == ACCUM);
    assign busy         = !in_ready;
    assign update_valid = (state_q == UPDATE);

    assign c1_x = cent_x[0];
    assign c1_y = cent_y[0];
    assign c2_x = cent_x[1];
    assign c2_y = cent_y[1];
    assign c3_x = cent_x[2];
    assign c3_y = cent_y[2];

    assign div_done  = (state_q == DIVIDE) && (bit_cnt == LAST_BIT);
    assign last_step = div_done && (div_idx == 3'd5);

    // Final quotient of the sixth division bypasses the shadow so UPDATE sees it immediately.
    assign result = {quo_next, shadow};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: epoch_end only matters in ACCUM; UPDATE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (epoch_end) state_d = DIVIDE;
            DIVIDE:  if (last_step) state_d = UPDATE;
            UPDATE:  state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Accumulate accepted samples; a saturated counter drops the sample and flags it; UPDATE clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_x        <= '0;
            sum_y        <= '0;
            cnt          <= '0;
            cnt_overflow <= 1'b0;
        end else if (state_q == UPDATE) begin
            sum_x        <= '0;
            sum_y        <= '0;
            cnt          <= '0;
            cnt_overflow <= 1'b0;
        end else if (in_valid && in_ready) begin
            for (int k = 0; k < 3; k++) begin
                if (cluster_id == 2'(k)) begin
                    if (&cnt[k]) begin
                        cnt_overflow <= 1'b1;
                    end else begin
                        sum_x[k] <= sum_x[k] + SUM_W'(data_x);
                        sum_y[k] <= sum_y[k] + SUM_W'(data_y);
                        cnt[k]   <= cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    // Select operands of the current division: even index = X sum, odd = Y sum of cluster idx/2.
    always_comb begin
        dividend = '0;
        divisor  = '0;
        case (div_idx)
            3'd0:    begin dividend = sum_x[0]; divisor = cnt[0]; end
            3'd1:    begin dividend = sum_y[0]; divisor = cnt[0]; end
            3'd2:    begin dividend = sum_x[1]; divisor = cnt[1]; end
            3'd3:    begin dividend = sum_y[1]; divisor = cnt[1]; end
            3'd4:    begin dividend = sum_x[2]; divisor = cnt[2]; end
            3'd5:    begin dividend = sum_y[2]; divisor = cnt[2]; end
            default: begin dividend = '0;       divisor = '0;     end
        endcase
    end

    assign dividend_ext = DIV_CYC'(dividend);

    // One restoring step: bring down the next dividend bit, subtract when it fits.
    always_comb begin
        rem_shift = {rem, dividend_ext[LAST_BIT - bit_cnt]};
        q_bit     = (rem_shift >= {1'b0, divisor});
        rem_next  = q_bit ? CNT_W'(rem_shift - {1'b0, divisor}) : rem_shift[CNT_W-1:0];
        quo_next  = {quo[DATA_W-2:0], q_bit};
    end

    // Divider sequencing: 32 steps per division, results parked in shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            bit_cnt <= '0;
            div_idx <= '0;
            shadow  <= '0;
        end else if (state_q == DIVIDE) begin
            if (div_done) begin
                for (int k = 0; k < 5; k++) begin
                    if (div_idx == 3'(k)) shadow[k] <= quo_next;
                end
                rem     <= '0;
                quo     <= '0;
                bit_cnt <= '0;
                div_idx <= div_idx + 3'd1;
            end else begin
                rem     <= rem_next;
                quo     <= quo_next;
                bit_cnt <= bit_cnt + 5'd1;
            end
        end else begin
            rem     <= '0;
            quo     <= '0;
            bit_cnt <= '0;
            div_idx <= '0;
        end
    end

    // Centroids change only on the last divide step; empty clusters keep their old position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cent_x <= {C3_X_RST, C2_X_RST, C1_X_RST};
            cent_y <= {C3_Y_RST, C2_Y_RST, C1_Y_RST};
        end else if (last_step) begin
            for (int k = 0; k < 3; k++) begin
                if (cnt[k] != '0) begin
                    cent_x[k] <= result[2*k];
                    cent_y[k] <= result[2*k+1];
                end
            end
        end
    end

endmodule

// File: tb/tb_centroid_update.sv
module tb_centroid_update;
    localparam int DW   = 16;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_x = '0, data_y = '0;
    logic [1:0]    cluster_id = '0;
    logic          in_valid = 1'b0;
    logic          epoch_end = 1'b0;
    logic          in_ready, update_valid, busy, cnt_overflow;
    logic [DW-1:0] c1_x, c1_y, c2_x, c2_y, c3_x, c3_y;

    int checks = 0;
    int errors = 0;

    // Reference model: plain sums, counts and centroid positions.
    longint        m_sx[3], m_sy[3];
    int            m_cnt[3];
    logic [DW-1:0] m_cx[3], m_cy[3];
    bit            m_ovf;
    int            bad;
    int            n;

    always #5 clk = ~clk;

    centroid_update #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_x(data_x), .data_y(data_y), .cluster_id(cluster_id),
        .in_valid(in_valid), .in_ready(in_ready), .epoch_end(epoch_end),
        .c1_x(c1_x), .c1_y(c1_y), .c2_x(c2_x), .c2_y(c2_y), .c3_x(c3_x), .c3_y(c3_y),
        .update_valid(update_valid), .busy(busy), .cnt_overflow(cnt_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset_cents();
        m_cx[0] = 16'h0200; m_cy[0] = 16'h0200;
        m_cx[1] = 16'h0600; m_cy[1] = 16'h0600;
        m_cx[2] = 16'h0180; m_cy[2] = 16'h0800;
    endtask

    task automatic m_clear();
        for (int k = 0; k < 3; k++) begin
            m_sx[k] = 0; m_sy[k] = 0; m_cnt[k] = 0;
        end
        m_ovf = 1'b0;
    endtask

    function automatic bit cents_match();
        return (c1_x === m_cx[0]) && (c1_y === m_cy[0]) && (c2_x === m_cx[1]) &&
               (c2_y === m_cy[1]) && (c3_x === m_cx[2]) && (c3_y === m_cy[2]);
    endfunction

    task automatic check_cents(input string tag);
        chk({tag, ".c1_x"}, c1_x, m_cx[0]);
        chk({tag, ".c1_y"}, c1_y, m_cy[0]);
        chk({tag, ".c2_x"}, c2_x, m_cx[1]);
        chk({tag, ".c2_y"}, c2_y, m_cy[1]);
        chk({tag, ".c3_x"}, c3_x, m_cx[2]);
        chk({tag, ".c3_y"}, c3_y, m_cy[2]);
    endtask

    // Present a sample for the next edge (block assumed to be accepting) and record it in the model.
    task automatic send_pre(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [1:0] id);
        data_x = x; data_y = y; cluster_id = id; in_valid = 1'b1;
        if (id != 2'd3) begin
            if (m_cnt[id] == CMAX) begin
                m_ovf = 1'b1;
            end else begin
                m_sx[id] += x; m_sy[id] += y; m_cnt[id]++;
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [1:0] id);
        send_pre(x, y, id);
        tick();
        in_valid = 1'b0;
    endtask

    // Pulse epoch_end and follow the whole DIVIDE/UPDATE sequence against the model.
    task automatic run_epoch(input string tag, input bit junk);
        epoch_end = 1'b1;
        tick();
        epoch_end = 1'b0;
        in_valid  = 1'b0;
        chk({tag, ".busy_start"}, busy, 1'b1);
        chk({tag, ".ready_start"}, in_ready, 1'b0);
        bad = 0;
        for (int i = 1; i < 192; i++) begin
            if (junk) begin
                in_valid   = 1'b1;
                data_x     = 16'($urandom);
                data_y     = 16'($urandom);
                cluster_id = 2'($urandom_range(0, 3));
                epoch_end  = (i == 50);
            end
            tick();
            if (update_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || !cents_match()) bad++;
        end
        in_valid  = 1'b0;
        epoch_end = 1'b0;
        chk({tag, ".divide_quiet"}, bad, 0);
        for (int k = 0; k < 3; k++) begin
            if (m_cnt[k] != 0) begin
                m_cx[k] = 16'(m_sx[k] / m_cnt[k]);
                m_cy[k] = 16'(m_sy[k] / m_cnt[k]);
            end
        end
        tick();
        chk({tag, ".update_valid"}, update_valid, 1'b1);
        chk({tag, ".busy_update"}, busy, 1'b1);
        check_cents(tag);
        tick();
        chk({tag, ".update_drop"}, update_valid, 1'b0);
        chk({tag, ".ready_back"}, in_ready, 1'b1);
        chk({tag, ".ovf_clear"}, cnt_overflow, 1'b0);
        m_clear();
    endtask

    initial begin
        m_reset_cents();
        m_clear();

        // Reset state
        tick(); tick();
        chk("rst.update_valid_low", update_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.busy", busy, 1'b0);
        chk("rst.update_valid", update_valid, 1'b0);
        chk("rst.ovf", cnt_overflow, 1'b0);
        check_cents("rst");

        // Average of two cluster-0 samples
        send(16'h0100, 16'h0300, 2'd0);
        send(16'h0200, 16'h0500, 2'd0);
        run_epoch("avg", 1'b0);
        chk("avg.c1_x_const", c1_x, 16'h0180);
        chk("avg.c1_y_const", c1_y, 16'h0400);

        // Truncating division
        send(16'h0001, 16'h0003, 2'd1);
        send(16'h0002, 16'h0003, 2'd1);
        send(16'h0002, 16'h0003, 2'd1);
        run_epoch("trunc", 1'b0);
        chk("trunc.c2_x_const", c2_x, 16'h0001);
        chk("trunc.c2_y_const", c2_y, 16'h0003);

        // Invalid cluster id plus junk traffic during DIVIDE
        send(16'hFFFF, 16'hFFFF, 2'd3);
        send(16'h0100, 16'h0300, 2'd0);
        send(16'h0200, 16'h0500, 2'd0);
        run_epoch("filter", 1'b1);
        chk("filter.c1_x_const", c1_x, 16'h0180);

        // Sample accepted together with epoch_end; extra epoch_end during DIVIDE
        send_pre(16'h0400, 16'h0400, 2'd2);
        run_epoch("simul", 1'b1);
        chk("simul.c3_x_const", c3_x, 16'h0400);
        chk("simul.c3_y_const", c3_y, 16'h0400);

        // Counter saturation
        for (int i = 0; i < CMAX; i++) send(16'($urandom), 16'($urandom), 2'd1);
        chk("ovf.before", cnt_overflow, 1'b0);
        send(16'hFFFF, 16'hFFFF, 2'd1);
        chk("ovf.after", cnt_overflow, m_ovf);
        chk("ovf.model", m_ovf, 1'b1);
        run_epoch("ovf", 1'b0);

        // Empty epoch
        run_epoch("empty", 1'b0);

        // Random epochs
        for (int e = 0; e < 4; e++) begin
            n = $urandom_range(20, 60);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) != 0)
                    send_pre(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
                else
                    in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b0;
            run_epoch("rand", 1'b0);
        end

        // Reset in the middle of DIVIDE
        send(16'h1234, 16'h2345, 2'd0);
        send(16'h0777, 16'h0888, 2'd1);
        epoch_end = 1'b1;
        tick();
        epoch_end = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        chk("mid.busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        m_reset_cents();
        m_clear();
        chk("mid.update_valid", update_valid, 1'b0);
        chk("mid.in_ready", in_ready, 1'b1);
        check_cents("mid_rst");
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (update_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        chk("mid.no_pulse", bad, 0);
        send(16'h0300, 16'h0500, 2'd2);
        run_epoch("after_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
